// File: rtl/alu_result_accumulator.sv
// Saturating/wrapping signed accumulator behind the ALU result stream, with a 2-entry record FIFO.
// Optional feature macro: ACC_SATURATE_EN (defined = saturate, undefined = wrap modulo 2^ACC_W).
module alu_result_accumulator #(
    parameter int ACC_W = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_result,
    input  logic             clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic [CNT_W-1:0] out_cnt,
    output logic             out_zero,
    output logic             out_neg,
    output logic             out_sat
);

    logic             acc_en_s;
    logic             pop_s;
    logic [ACC_W-1:0] acc_r;
    logic [CNT_W-1:0] cnt_r;
    logic [ACC_W-1:0] base_acc_s;
    logic [CNT_W-1:0] base_cnt_s;
    logic [ACC_W-1:0] new_acc_s;
    logic [CNT_W-1:0] new_cnt_s;
    logic [1:0]       count_r;
    logic             wr_ptr_r;
    logic             rd_ptr_r;
    logic [ACC_W-1:0] acc_mem_r  [2];
    logic [CNT_W-1:0] cnt_mem_r  [2];
    logic             zero_mem_r [2];
    logic             neg_mem_r  [2];

    // Handshake: ready depends only on FIFO occupancy, never on out_ready.
    always_comb begin
        in_ready  = rst_n && (count_r < 2'd2);
        out_valid = (count_r != 2'd0);
        acc_en_s  = in_valid && in_ready;
        pop_s     = out_valid && out_ready;
    end

    // Clear replaces the running state with zero as the base for this cycle's sample.
    always_comb begin
        if (clear) begin
            base_acc_s = {ACC_W{1'b0}};
            base_cnt_s = {CNT_W{1'b0}};
        end else begin
            base_acc_s = acc_r;
            base_cnt_s = cnt_r;
        end
        new_cnt_s = base_cnt_s + {{(CNT_W-1){1'b0}}, 1'b1};
    end

`ifdef ACC_SATURATE_EN
    logic [ACC_W:0] sum_s;
    logic           sat_s;
    logic           sat_mem_r [2];

    // One guard bit above the accumulator exposes overflow in either direction.
    always_comb begin
        sum_s = {base_acc_s[ACC_W-1], base_acc_s}
              + {{(ACC_W+1-8){in_result[7]}}, in_result};
        case ({sum_s[ACC_W], sum_s[ACC_W-1]})
            2'b01: begin
                new_acc_s = {1'b0, {(ACC_W-1){1'b1}}};
                sat_s     = 1'b1;
            end
            2'b10: begin
                new_acc_s = {1'b1, {(ACC_W-1){1'b0}}};
                sat_s     = 1'b1;
            end
            default: begin
                new_acc_s = sum_s[ACC_W-1:0];
                sat_s     = 1'b0;
            end
        endcase
    end

    // Saturation flag storage exists only in the saturating build.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sat_mem_r[0] <= 1'b0;
            sat_mem_r[1] <= 1'b0;
        end else if (acc_en_s) begin
            sat_mem_r[wr_ptr_r] <= sat_s;
        end else begin
            sat_mem_r[wr_ptr_r] <= sat_mem_r[wr_ptr_r];
        end
    end

    assign out_sat = sat_mem_r[rd_ptr_r];
`else
    logic [ACC_W-1:0] sum_s;

    // Plain two's-complement wrap modulo 2^ACC_W.
    always_comb begin
        sum_s     = base_acc_s + {{(ACC_W-8){in_result[7]}}, in_result};
        new_acc_s = sum_s;
    end

    assign out_sat = 1'b0;
`endif

    // Running accumulator and sample counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_r <= {ACC_W{1'b0}};
            cnt_r <= {CNT_W{1'b0}};
        end else if (acc_en_s) begin
            acc_r <= new_acc_s;
            cnt_r <= new_cnt_s;
        end else if (clear) begin
            acc_r <= {ACC_W{1'b0}};
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            acc_r <= acc_r;
            cnt_r <= cnt_r;
        end
    end

    // Record FIFO: flags are frozen at write time so the head stays stable under backpressure.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_r  <= 2'd0;
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                acc_mem_r[i]  <= {ACC_W{1'b0}};
                cnt_mem_r[i]  <= {CNT_W{1'b0}};
                zero_mem_r[i] <= 1'b0;
                neg_mem_r[i]  <= 1'b0;
            end
        end else begin
            if (acc_en_s) begin
                acc_mem_r[wr_ptr_r]  <= new_acc_s;
                cnt_mem_r[wr_ptr_r]  <= new_cnt_s;
                zero_mem_r[wr_ptr_r] <= (new_acc_s == {ACC_W{1'b0}});
                neg_mem_r[wr_ptr_r]  <= new_acc_s[ACC_W-1];
                wr_ptr_r             <= ~wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            case ({acc_en_s, pop_s})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Head-of-FIFO record presentation.
    always_comb begin
        out_acc  = acc_mem_r[rd_ptr_r];
        out_cnt  = cnt_mem_r[rd_ptr_r];
        out_zero = zero_mem_r[rd_ptr_r];
        out_neg  = neg_mem_r[rd_ptr_r];
    end

endmodule
